// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the per-stage control-vector layout used by the pipeline-register wrappers,
// and the NOP encoding that the flush/bubble paths load into a register.
package hazard_pkg;

    // Hazard sequencer states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // Control-vector field order, MSB first. The pipeline-register wrappers
    // slice this same packed layout, so fields must only ever be appended.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Canonical RV32 NOP (addi x0, x0, 0) loaded by a flush or bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Decoded control words, one per hazard situation.
    localparam ctrl_t CTRL_RUN      = ctrl_t'(8'b11111_000);
    localparam ctrl_t CTRL_HALT     = ctrl_t'(8'b00000_000);
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(8'b00001_001);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b11111_110);
    localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(8'b00111_010);

    // Data-side helper for the register wrappers: substitute the NOP when the
    // stage is being flushed or bubbled.
    function automatic logic [31:0] nop_select(input logic kill, input logic [31:0] instr);
        return kill ? NOP_INSTR : instr;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic at_max;

    assign at_max = (count == {W{1'b1}});

    // Count register: async reset, sync clear, saturating increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the five-stage core. Produces per-stage
// write enables, flushes and the MEM/WB bubble for load-use stalls, taken
// branches and multi-cycle data-memory waits, with a memory-wait timeout
// that parks the core in HALT, plus saturating stall/flush counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic [REG_W-1:0] rd_ID_EX,
    input  logic             mem_read_ID_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    input  logic             clr_cnt,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wide enough to hold TIMEOUT itself, so the compare value never wraps.
    localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;

    logic  rs1_hit;
    logic  rs2_hit;
    logic  load_use;
    logic  mem_stall;
    ctrl_t ctrl;
    logic  stall_inc;
    logic  flush_inc;

    // Hazard detection: x0 is never a real dependency, and the memory stall
    // is ignored once halted so HALT decoding stays absolute.
    always_comb begin
        rs1_hit   = uses_rs1_ID && (rs1_ID == rd_ID_EX);
        rs2_hit   = uses_rs2_ID && (rs2_ID == rd_ID_EX);
        load_use  = mem_read_ID_EX && (rd_ID_EX != '0) && (rs1_hit || rs2_hit);
        mem_stall = (state != HALT) && dmem_req_MEM && !dmem_ready;
    end

    // Next-state and wait-timer logic. The RUN cycle that first sees the
    // stall counts as wait cycle one, so TIMEOUT frozen cycles precede HALT.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                wait_cnt_nxt = '0;
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Output decode in priority order: halt, memory freeze, branch, load-use.
    // A held branch or load-use during a freeze naturally takes effect in the
    // release cycle because EX is frozen and still presents it.
    always_comb begin
        ctrl      = CTRL_RUN;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (state == HALT) begin
            ctrl = CTRL_HALT;
        end else if (mem_stall) begin
            ctrl      = CTRL_FREEZE;
            stall_inc = 1'b1;
        end else if (branch_taken_EX) begin
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
        end else if (load_use) begin
            ctrl      = CTRL_LOAD_USE;
            stall_inc = 1'b1;
        end
    end

    // State and wait-timer registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Sticky timeout flag: set when the FSM drops into HALT, cleared by reset only.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mem_error <= 1'b0;
        end else if (state_nxt == HALT) begin
            mem_error <= 1'b1;
        end
    end

    assign pc_we         = ctrl.pc_we;
    assign if_id_we      = ctrl.if_id_we;
    assign id_ex_we      = ctrl.id_ex_we;
    assign ex_mem_we     = ctrl.ex_mem_we;
    assign mem_wb_we     = ctrl.mem_wb_we;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .arst  (arst),
        .clr   (clr_cnt),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .arst  (arst),
        .clr   (clr_cnt),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller (TIMEOUT=4, 8-bit counters).
module tb_hazard_controller;

    localparam int REG_W   = 5;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    // {pc, if_id, id_ex, ex_mem, mem_wb we, if_id_flush, id_ex_flush, bubble, mem_error}
    localparam logic [8:0] C_RUN  = 9'b11111_000_0;
    localparam logic [8:0] C_MEM  = 9'b00001_001_0;
    localparam logic [8:0] C_BR   = 9'b11111_110_0;
    localparam logic [8:0] C_LU   = 9'b00111_010_0;
    localparam logic [8:0] C_HALT = 9'b00000_000_1;

    logic             clk = 1'b0;
    logic             arst;
    logic [REG_W-1:0] rs1_ID;
    logic [REG_W-1:0] rs2_ID;
    logic             uses_rs1_ID;
    logic             uses_rs2_ID;
    logic [REG_W-1:0] rd_ID_EX;
    logic             mem_read_ID_EX;
    logic             branch_taken_EX;
    logic             dmem_req_MEM;
    logic             dmem_ready;
    logic             clr_cnt;
    logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble, mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [8:0]       ctl;

    int checks = 0;
    int passed = 0;

    hazard_controller #(
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .uses_rs1_ID     (uses_rs1_ID),
        .uses_rs2_ID     (uses_rs2_ID),
        .rd_ID_EX        (rd_ID_EX),
        .mem_read_ID_EX  (mem_read_ID_EX),
        .branch_taken_EX (branch_taken_EX),
        .dmem_req_MEM    (dmem_req_MEM),
        .dmem_ready      (dmem_ready),
        .clr_cnt         (clr_cnt),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_we        (id_ex_we),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_error       (mem_error),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                  if_id_flush, id_ex_flush, mem_wb_bubble, mem_error};

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_ID          = '0;
        rs2_ID          = '0;
        uses_rs1_ID     = 1'b0;
        uses_rs2_ID     = 1'b0;
        rd_ID_EX        = '0;
        mem_read_ID_EX  = 1'b0;
        branch_taken_EX = 1'b0;
        dmem_req_MEM    = 1'b0;
        dmem_ready      = 1'b0;
        clr_cnt         = 1'b0;
    endtask

    task automatic clear_counters();
        idle();
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        idle();
        #3;
        checks++;
        if (ctl !== C_RUN) $display("FAIL reset_ctl got=%b want=%b", ctl, C_RUN); else passed++;
        checks++;
        if (stall_cnt !== 8'd0) $display("FAIL reset_stall got=%0d want=0", stall_cnt); else passed++;
        checks++;
        if (flush_cnt !== 8'd0) $display("FAIL reset_flush got=%0d want=0", flush_cnt); else passed++;
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd5; rs1_ID = 5'd5; uses_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctl !== C_LU) $display("FAIL reset_run_decode got=%b want=%b", ctl, C_LU); else passed++;
        idle();
        cyc();
        arst = 1'b0;
        cyc();
        #2;
        checks++;
        if (ctl !== C_RUN) $display("FAIL post_reset_ctl got=%b want=%b", ctl, C_RUN); else passed++;
    endtask

    task automatic test_load_use();
        clear_counters();
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd5; rs1_ID = 5'd5; uses_rs1_ID = 1'b1;
        #2;
        checks++;
        if (ctl !== C_LU) $display("FAIL lu_rs1 got=%b want=%b", ctl, C_LU); else passed++;
        cyc();
        idle();
        #2;
        checks++;
        if (stall_cnt !== 8'd1) $display("FAIL lu_rs1_cnt got=%0d want=1", stall_cnt); else passed++;
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd0; rs1_ID = 5'd0; uses_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) $display("FAIL lu_x0 got=%b want=%b", ctl, C_RUN); else passed++;
        cyc();
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd7; rs2_ID = 5'd7; uses_rs2_ID = 1'b1;
        uses_rs1_ID = 1'b0; rs1_ID = 5'd1;
        #2;
        checks++;
        if (ctl !== C_LU) $display("FAIL lu_rs2 got=%b want=%b", ctl, C_LU); else passed++;
        cyc();
        uses_rs2_ID = 1'b0;
        #2;
        checks++;
        if (ctl !== C_RUN) $display("FAIL lu_rs2_unused got=%b want=%b", ctl, C_RUN); else passed++;
        checks++;
        if (stall_cnt !== 8'd2) $display("FAIL lu_rs2_cnt got=%0d want=2", stall_cnt); else passed++;
        cyc();
        idle();
    endtask

    task automatic test_mem_wait();
        clear_counters();
        dmem_req_MEM = 1'b1; dmem_ready = 1'b0; branch_taken_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (ctl !== C_MEM) $display("FAIL wait_freeze%0d got=%b want=%b", i, ctl, C_MEM); else passed++;
            cyc();
        end
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_BR) $display("FAIL wait_release got=%b want=%b", ctl, C_BR); else passed++;
        cyc();
        idle();
        #2;
        checks++;
        if (stall_cnt !== 8'd3) $display("FAIL wait_stall_cnt got=%0d want=3", stall_cnt); else passed++;
        checks++;
        if (flush_cnt !== 8'd1) $display("FAIL wait_flush_cnt got=%0d want=1", flush_cnt); else passed++;
        dmem_req_MEM = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) $display("FAIL req_and_ready got=%b want=%b", ctl, C_RUN); else passed++;
        cyc();
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (ctl !== C_MEM) $display("FAIL wait2_freeze%0d got=%b want=%b", i, ctl, C_MEM); else passed++;
            cyc();
        end
        dmem_ready = 1'b1;
        #2;
        checks++;
        if (ctl !== C_RUN) $display("FAIL wait2_release got=%b want=%b", ctl, C_RUN); else passed++;
        cyc();
        idle();
        #2;
        checks++;
        if (stall_cnt !== 8'd6) $display("FAIL wait2_stall_cnt got=%0d want=6", stall_cnt); else passed++;
        checks++;
        if (ctl !== C_RUN) $display("FAIL wait2_no_halt got=%b want=%b", ctl, C_RUN); else passed++;
    endtask

    task automatic test_branch();
        clear_counters();
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd9; rs2_ID = 5'd9; uses_rs2_ID = 1'b1;
        branch_taken_EX = 1'b1;
        #2;
        checks++;
        if (ctl !== C_BR) $display("FAIL branch_over_lu got=%b want=%b", ctl, C_BR); else passed++;
        cyc();
        branch_taken_EX = 1'b0;
        #2;
        checks++;
        if (flush_cnt !== 8'd1) $display("FAIL branch_flush_cnt got=%0d want=1", flush_cnt); else passed++;
        checks++;
        if (stall_cnt !== 8'd0) $display("FAIL branch_stall_cnt got=%0d want=0", stall_cnt); else passed++;
        checks++;
        if (ctl !== C_LU) $display("FAIL lu_after_branch got=%b want=%b", ctl, C_LU); else passed++;
        cyc();
        idle();
    endtask

    task automatic test_timeout();
        clear_counters();
        dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #2;
            checks++;
            if (ctl !== C_MEM) $display("FAIL to_freeze%0d got=%b want=%b", i, ctl, C_MEM); else passed++;
            cyc();
        end
        #2;
        checks++;
        if (ctl !== C_HALT) $display("FAIL to_halt got=%b want=%b", ctl, C_HALT); else passed++;
        dmem_ready = 1'b1; branch_taken_EX = 1'b1;
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd4; rs1_ID = 5'd4; uses_rs1_ID = 1'b1;
        #1;
        checks++;
        if (ctl !== C_HALT) $display("FAIL halt_ignores got=%b want=%b", ctl, C_HALT); else passed++;
        cyc();
        #2;
        checks++;
        if (ctl !== C_HALT) $display("FAIL halt_sticky got=%b want=%b", ctl, C_HALT); else passed++;
        checks++;
        if (stall_cnt !== 8'd4) $display("FAIL to_stall_cnt got=%0d want=4", stall_cnt); else passed++;
        checks++;
        if (flush_cnt !== 8'd0) $display("FAIL to_flush_cnt got=%0d want=0", flush_cnt); else passed++;
        idle();
        arst = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) $display("FAIL arst_from_halt got=%b want=%b", ctl, C_RUN); else passed++;
        checks++;
        if (stall_cnt !== 8'd0) $display("FAIL arst_stall_cnt got=%0d want=0", stall_cnt); else passed++;
        cyc();
        arst = 1'b0;
        cyc();
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd4; rs1_ID = 5'd4; uses_rs1_ID = 1'b1;
        #2;
        checks++;
        if (ctl !== C_LU) $display("FAIL run_after_arst got=%b want=%b", ctl, C_LU); else passed++;
        cyc();
        idle();
    endtask

    task automatic test_saturation();
        clear_counters();
        mem_read_ID_EX = 1'b1; rd_ID_EX = 5'd3; rs1_ID = 5'd3; uses_rs1_ID = 1'b1;
        repeat (255) cyc();
        #2;
        checks++;
        if (stall_cnt !== 8'hFF) $display("FAIL sat_reach got=%0h want=ff", stall_cnt); else passed++;
        cyc();
        #2;
        checks++;
        if (stall_cnt !== 8'hFF) $display("FAIL sat_hold got=%0h want=ff", stall_cnt); else passed++;
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        #2;
        checks++;
        if (stall_cnt !== 8'd0) $display("FAIL clr_over_inc got=%0d want=0", stall_cnt); else passed++;
        cyc();
        #2;
        checks++;
        if (stall_cnt !== 8'd1) $display("FAIL count_after_clr got=%0d want=1", stall_cnt); else passed++;
        idle();
        branch_taken_EX = 1'b1;
        cyc();
        cyc();
        #2;
        checks++;
        if (flush_cnt !== 8'd2) $display("FAIL flush_two got=%0d want=2", flush_cnt); else passed++;
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        #2;
        checks++;
        if (flush_cnt !== 8'd0) $display("FAIL flush_clr got=%0d want=0", flush_cnt); else passed++;
        idle();
        cyc();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
